// File: rtl/demux1_2_feeder_if.sv
// rtl/demux1_2_feeder_if.sv - stream and demux-drive signals of the 1-to-2 demux feeder
// master = upstream/channel side, slave = feeder.
interface demux1_2_feeder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dest;
  logic             mode;
  logic [WIDTH-1:0] dmx_i;
  logic             dmx_s;
  logic             out_valid;
  logic [1:0]       ack;

  modport master (
    output in_valid, in_data, in_dest, mode, ack,
    input  in_ready, dmx_i, dmx_s, out_valid
  );

  modport slave (
    input  in_valid, in_data, in_dest, mode, ack,
    output in_ready, dmx_i, dmx_s, out_valid
  );
endinterface

// File: rtl/demux1_2_feeder.sv
// rtl/demux1_2_feeder.sv - FIFO-buffered feeder holding each word on the demux until acked
// Routing is per-word (stored dest) or round-robin, chosen when the word leaves the FIFO.
module demux1_2_feeder #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  demux1_2_feeder_if.slave           bus,
  output logic [$clog2(DEPTH):0]     o_fifo_cnt,
  output logic [CNTW-1:0]            o_sent0,
  output logic [CNTW-1:0]            o_sent1
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             r_rr;
  logic [WIDTH-1:0] r_dmx_i;
  logic             r_dmx_s;
  logic [CNTW-1:0]  r_sent0;
  logic [CNTW-1:0]  r_sent1;

  logic             w_push;
  logic             w_ack;
  logic             w_pop;
  logic [WIDTH:0]   w_head;

  assign w_head = r_mem[r_rd];
  assign w_push = bus.in_valid && bus.in_ready;
  assign w_ack  = (r_state == SEND) && bus.ack[r_dmx_s];
  // Pop decisions use the registered count, so a same-cycle push never passes through.
  assign w_pop  = (r_cnt != '0) && ((r_state == IDLE) || w_ack);

  assign bus.in_ready  = (r_cnt != (AW+1)'(DEPTH));
  assign bus.dmx_i     = r_dmx_i;
  assign bus.dmx_s     = r_dmx_s;
  assign bus.out_valid = (r_state == SEND);
  assign o_fifo_cnt    = r_cnt;
  assign o_sent0       = r_sent0;
  assign o_sent1       = r_sent1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_rr    <= 1'b0;
      r_dmx_i <= '0;
      r_dmx_s <= 1'b0;
      r_sent0 <= '0;
      r_sent1 <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {bus.in_dest, bus.in_data};
        r_wr        <= r_wr + 1'b1;
      end

      if (w_pop) begin
        r_rd    <= r_rd + 1'b1;
        r_dmx_i <= w_head[WIDTH-1:0];
        if (bus.mode) begin
          r_dmx_s <= r_rr;
          r_rr    <= ~r_rr;
        end else begin
          r_dmx_s <= w_head[WIDTH];
        end
      end

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      case (r_state)
        IDLE: begin
          if (w_pop) r_state <= SEND;
        end
        SEND: begin
          if (w_ack) begin
            if (r_dmx_s) r_sent1 <= r_sent1 + 1'b1;
            else         r_sent0 <= r_sent0 + 1'b1;
            if (!w_pop) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
